// File: rtl/demux31_tdm_if.sv
// -----------------------------------------------------------------------------
// demux31_tdm_if
//
// Bundles the shared TDM lane (in_*) and the per-channel results (out_*,
// status strobes, counters) of the 3-channel TDM demultiplexer.
//
//   master : the side that drives the lane and observes the channel outputs
//   slave  : the demultiplexer itself
//
// Parameters:
//   WIDTH  - lane / channel data width
//   FCNT_W - completed-frame counter width
//   ECNT_W - saturating sync-error counter width
// -----------------------------------------------------------------------------
interface demux31_tdm_if #(
    parameter int WIDTH  = 8,
    parameter int FCNT_W = 16,
    parameter int ECNT_W = 8
);
    // Lane side
    logic              in_valid;
    logic              in_sof;
    logic [WIDTH-1:0]  in_data;

    // Channel side
    logic [WIDTH-1:0]  out_d0;
    logic [WIDTH-1:0]  out_d1;
    logic [WIDTH-1:0]  out_d2;
    logic [2:0]        out_valid;
    logic              frame_done;
    logic              sync_err;
    logic              locked;
    logic [FCNT_W-1:0] frame_cnt;
    logic [ECNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_sof, in_data,
        input  out_d0, out_d1, out_d2, out_valid,
        input  frame_done, sync_err, locked, frame_cnt, err_cnt
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output out_d0, out_d1, out_d2, out_valid,
        output frame_done, sync_err, locked, frame_cnt, err_cnt
    );
endinterface

// File: rtl/demux31_tdm.sv
// -----------------------------------------------------------------------------
// demux31_tdm
//
// Receive side of a 3:1 time-division-multiplexed lane. Beats arrive as
// slots 0,1,2 of a frame, slot 0 flagged by in_sof. Each accepted beat is
// written into the matching registered channel output, a small HUNT/LOCKED
// machine tracks frame alignment, and framing violations are reported.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   lane   - demux31_tdm_if.slave:
//              in_valid/in_sof/in_data     shared lane beat
//              out_d0/out_d1/out_d2        last captured data per slot
//              out_valid[2:0]              one-cycle update strobe per channel
//              frame_done                  pulse when an aligned frame completes
//              sync_err                    pulse on a framing violation
//              locked                      high while aligned (LOCKED)
//              frame_cnt                   completed frames, wrapping
//              err_cnt                     sync errors, saturating
//
// All outputs are registered: a beat taken at edge k is visible after edge k.
// -----------------------------------------------------------------------------
module demux31_tdm #(
    parameter int WIDTH  = 8,
    parameter int FCNT_W = 16,
    parameter int ECNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux31_tdm_if.slave         lane
);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_t            r_state;
    logic [1:0]        r_slot;         // slot index expected for the next beat

    logic [WIDTH-1:0]  r_d0;
    logic [WIDTH-1:0]  r_d1;
    logic [WIDTH-1:0]  r_d2;
    logic [2:0]        r_valid;
    logic              r_frame_done;
    logic              r_sync_err;
    logic [FCNT_W-1:0] r_frame_cnt;
    logic [ECNT_W-1:0] r_err_cnt;

    // -------------------------------------------------------------------------
    // Next-state / decision wires
    // -------------------------------------------------------------------------
    state_t            w_state_nxt;
    logic [1:0]        w_slot_nxt;
    logic [2:0]        w_cap;          // per-channel capture enable this beat
    logic              w_done;         // aligned frame completes this beat
    logic              w_err;          // framing violation this beat

    // -------------------------------------------------------------------------
    // Next-state and decision logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_cap       = 3'b000;
        w_done      = 1'b0;
        w_err       = 1'b0;

        if (lane.in_valid) begin
            unique case (r_state)
                ST_HUNT: begin
                    // Non-SOF beats are simply dropped while searching.
                    if (lane.in_sof) begin
                        w_cap[0]    = 1'b1;
                        w_slot_nxt  = 2'd1;
                        w_state_nxt = ST_LOCKED;
                    end
                end

                ST_LOCKED: begin
                    if (lane.in_sof) begin
                        // A SOF anywhere but slot 0 is an early SOF: flag it
                        // and realign on this beat, dropping the partial frame.
                        w_err      = (r_slot != 2'd0);
                        w_cap[0]   = 1'b1;
                        w_slot_nxt = 2'd1;
                    end else begin
                        case (r_slot)
                            2'd1: begin
                                w_cap[1]   = 1'b1;
                                w_slot_nxt = 2'd2;
                            end
                            2'd2: begin
                                w_cap[2]   = 1'b1;
                                w_done     = 1'b1;
                                w_slot_nxt = 2'd0;
                            end
                            default: begin
                                // Slot 0 without SOF: alignment is lost.
                                w_err       = 1'b1;
                                w_slot_nxt  = 2'd0;
                                w_state_nxt = ST_HUNT;
                            end
                        endcase
                    end
                end

                default: begin
                    w_slot_nxt  = 2'd0;
                    w_state_nxt = ST_HUNT;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state <= ST_HUNT;
            r_slot  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Channel data registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data registers are reset even though they are plain
        // holding registers, because every channel output must read 0 from reset.
        if (!rst_n) begin
            r_d0 <= '0;
            r_d1 <= '0;
            r_d2 <= '0;
        end else begin
            if (w_cap[0]) r_d0 <= lane.in_data;
            if (w_cap[1]) r_d1 <= lane.in_data;
            if (w_cap[2]) r_d2 <= lane.in_data;
        end
    end

    // -------------------------------------------------------------------------
    // Strobes: w_* are zero whenever no qualifying beat arrives, so each
    // register is high for exactly one cycle per event.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 3'b000;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_valid      <= w_cap;
            r_frame_done <= w_done;
            r_sync_err   <= w_err;
        end
    end

    // -------------------------------------------------------------------------
    // Counters: frames wrap, errors stick at all-ones.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_done)
                r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
            if (w_err && (r_err_cnt != {ECNT_W{1'b1}}))
                r_err_cnt <= r_err_cnt + ECNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Output drive
    // -------------------------------------------------------------------------
    assign lane.out_d0     = r_d0;
    assign lane.out_d1     = r_d1;
    assign lane.out_d2     = r_d2;
    assign lane.out_valid  = r_valid;
    assign lane.frame_done = r_frame_done;
    assign lane.sync_err   = r_sync_err;
    assign lane.locked     = (r_state == ST_LOCKED);
    assign lane.frame_cnt  = r_frame_cnt;
    assign lane.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_demux31_tdm.sv
// -----------------------------------------------------------------------------
// tb_demux31_tdm
//
// Directed and randomized stimulus for demux31_tdm, compared beat by beat
// against a behavioural model of the framing rules. The frame counter is
// built 10 bits wide so its wrap is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_demux31_tdm;

    localparam int WIDTH  = 8;
    localparam int FCNT_W = 10;
    localparam int ECNT_W = 8;
    localparam int FMOD   = 1 << FCNT_W;
    localparam int EMAX   = (1 << ECNT_W) - 1;

    logic clk;
    logic rst_n;

    demux31_tdm_if #(.WIDTH(WIDTH), .FCNT_W(FCNT_W), .ECNT_W(ECNT_W)) bus ();

    demux31_tdm #(.WIDTH(WIDTH), .FCNT_W(FCNT_W), .ECNT_W(ECNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lane  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // -------------------------------------------------------------------------
    // Reference model: frame position, channel contents and event totals
    // -------------------------------------------------------------------------
    bit         m_lock;
    int         m_pos;            // position of the next beat within a frame
    logic [7:0] m_d [3];
    int         m_frames;
    int         m_errs;
    logic [2:0] e_valid;
    bit         e_done;
    bit         e_err;

    task automatic m_reset();
        m_lock   = 0;
        m_pos    = 0;
        m_d[0]   = '0;
        m_d[1]   = '0;
        m_d[2]   = '0;
        m_frames = 0;
        m_errs   = 0;
        e_valid  = '0;
        e_done   = 0;
        e_err    = 0;
    endtask

    task automatic m_beat(input bit v, input bit sof, input logic [7:0] d);
        e_valid = '0;
        e_done  = 0;
        e_err   = 0;
        if (v) begin
            if (!m_lock) begin
                if (sof) begin
                    m_d[0] = d; e_valid = 3'b001; m_pos = 1; m_lock = 1;
                end
            end else if (sof) begin
                if (m_pos != 0) begin e_err = 1; m_errs++; end
                m_d[0] = d; e_valid = 3'b001; m_pos = 1;
            end else if (m_pos == 0) begin
                e_err = 1; m_errs++; m_lock = 0;
            end else begin
                m_d[m_pos] = d;
                e_valid    = 3'(1 << m_pos);
                if (m_pos == 2) begin
                    e_done = 1; m_frames++; m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_d0"},     32'(bus.out_d0),     32'(m_d[0]));
        chk({tag, ".out_d1"},     32'(bus.out_d1),     32'(m_d[1]));
        chk({tag, ".out_d2"},     32'(bus.out_d2),     32'(m_d[2]));
        chk({tag, ".out_valid"},  32'(bus.out_valid),  32'(e_valid));
        chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'(e_done));
        chk({tag, ".sync_err"},   32'(bus.sync_err),   32'(e_err));
        chk({tag, ".locked"},     32'(bus.locked),     32'(m_lock));
        chk({tag, ".frame_cnt"},  32'(bus.frame_cnt),  32'(m_frames % FMOD));
        chk({tag, ".err_cnt"},    32'(bus.err_cnt),    32'((m_errs > EMAX) ? EMAX : m_errs));
    endtask

    // Drive one lane cycle (called #1 after a rising edge), then check the
    // registered result #1 after the next rising edge.
    task automatic beat(input string tag, input bit v, input bit sof, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        m_beat(v, sof, d);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++)
            beat(tag, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    endtask

    task automatic do_reset(input string tag);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        rst_n        = 1'b0;
        m_reset();
        #3;
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        rst_n        = 1'b0;
        m_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset_release");

        // Clean frame from HUNT
        beat("f1_s0", 1, 1, 8'h11);
        beat("f1_s1", 1, 0, 8'h22);
        beat("f1_s2", 1, 0, 8'h33);

        // Missing SOF drops alignment, then HUNT discards non-SOF beats
        beat("miss_sof", 1, 0, 8'h44);
        beat("hunt_aa",  1, 0, 8'hAA);
        beat("hunt_bb",  1, 0, 8'hBB);
        beat("hunt_sof", 1, 1, 8'h01);
        beat("f2_s1",    1, 0, 8'h02);
        beat("f2_s2",    1, 0, 8'h03);

        // Early SOF while locked
        beat("early_s0",  1, 1, 8'h10);
        beat("early_s1",  1, 0, 8'h20);
        beat("early_sof", 1, 1, 8'h30);
        beat("early_f1",  1, 0, 8'h21);
        beat("early_f2",  1, 0, 8'h31);
        beat("miss_sof2", 1, 0, 8'h44);

        // Gapped frame
        beat("gap_s0", 1, 1, 8'h01);
        idle("gap_a", 3);
        beat("gap_s1", 1, 0, 8'h02);
        idle("gap_b", 3);
        beat("gap_s2", 1, 0, 8'h03);
        idle("gap_c", 3);

        // Asynchronous reset mid-frame, between clock edges
        beat("ar_s0", 1, 1, 8'h55);
        beat("ar_s1", 1, 0, 8'h66);
        #3;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        m_reset();
        #1;
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("async_release");

        // Error counter saturation: back-to-back SOFs are all early after the first
        beat("sat_first", 1, 1, 8'h00);
        for (int i = 0; i < 300; i++)
            beat("sat", 1, 1, 8'(i));

        // Frame counter wrap: 2^FCNT_W + 1 frames
        do_reset("wrap_reset");
        for (int i = 0; i < FMOD + 1; i++) begin
            beat("wrap_s0", 1, 1, 8'($urandom));
            beat("wrap_s1", 1, 0, 8'($urandom));
            beat("wrap_s2", 1, 0, 8'($urandom));
        end
        chk("wrap_frame_cnt", 32'(bus.frame_cnt), 32'd1);

        // Randomized traffic: mostly well-formed, occasional SOF corruption and gaps
        do_reset("rand_reset");
        for (int i = 0; i < 3000; i++) begin
            bit v;
            bit sof;
            v   = ($urandom_range(0, 3) != 0);
            sof = (m_pos == 0) ^ ($urandom_range(0, 9) == 0);
            if (!m_lock && $urandom_range(0, 3) == 0) sof = 1'b0;
            beat("rand", v, sof, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demux31_tdm.md
Name: demux31_tdm

Overview:
Receive-side counterpart of the 3:1 selector path. It accepts a time-division-multiplexed stream on one data lane, where beats are slots 0,1,2 of a frame and slot 0 is marked by a start-of-frame flag. It distributes each beat to a registered per-channel output, tracks frame alignment with a small state machine, and reports framing errors. It sits directly after the shared lane and feeds three independent channel consumers.

Parameters:
WIDTH, 8, data width of the lane and of each channel output
FCNT_W, 16, width of the completed-frame counter
ECNT_W, 8, width of the saturating sync-error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  lane beat is present this cycle
in_sof  input  1  beat is slot 0 of a frame; ignored when in_valid=0
in_data  input  WIDTH  lane data
out_d0  output  WIDTH  last captured slot-0 data
out_d1  output  WIDTH  last captured slot-1 data
out_d2  output  WIDTH  last captured slot-2 data
out_valid  output  3  one-cycle strobe per channel; bit n means out_dn was updated
frame_done  output  1  one-cycle pulse when slot 2 of an aligned frame is captured
sync_err  output  1  one-cycle pulse on a framing violation
locked  output  1  high while in LOCKED state
frame_cnt  output  FCNT_W  completed frames, wraps modulo 2^FCNT_W
err_cnt  output  ECNT_W  sync errors, saturates at all-ones

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs are 0.
  - State is HUNT and the slot index is 0.
  - Reset asserted mid-frame discards the partial frame. No pulse is emitted.
- All outputs are registered. A beat accepted at edge k appears at the outputs after edge k, giving 1-cycle latency.
- Strobes (out_valid, frame_done, sync_err) are high for exactly one cycle per event. Otherwise they are 0.
- in_valid=0: state, slot index and data outputs hold. No strobes.
- HUNT state:
  - in_valid=1 and in_sof=1: capture in_data to out_d0, pulse out_valid[0], set slot=1, go to LOCKED.
  - in_valid=1 and in_sof=0: discard the beat. No strobe and no error. Stay in HUNT.
- LOCKED state, in_valid=1, by case:
  - in_sof=0 and slot=1 or 2: capture to out_d[slot] and pulse out_valid[slot].
    - If slot=2: also pulse frame_done, increment frame_cnt, set slot=0.
    - Otherwise slot=slot+1.
  - in_sof=1 and slot=0: normal frame start. Capture to out_d0, pulse out_valid[0], set slot=1.
  - in_sof=1 and slot≠0 (early SOF): pulse sync_err and increment err_cnt. Resynchronise by treating the beat as slot 0: capture to out_d0, pulse out_valid[0], set slot=1, stay LOCKED. The partial frame is not counted.
  - in_sof=0 and slot=0 (missing SOF): pulse sync_err and increment err_cnt. Discard the beat, set slot=0, go to HUNT.
- locked equals (state==LOCKED).
- Counter rules:
  - frame_cnt wraps from all-ones to 0.
  - err_cnt holds at all-ones. It never wraps.
- Untouched channel registers keep their previous value on any beat.

Test Plan:
- Reset release, then beats (sof,data) = (1,0x11),(0,0x22),(0,0x33) with in_valid=1 → out_d0=0x11, out_d1=0x22, out_d2=0x33. Strobes out_valid=001, 010, 100 on successive cycles. frame_done pulses with the 0x33 update. frame_cnt=1. locked=1 from the cycle after the first beat.
- In HUNT, beats (0,0xAA),(0,0xBB) then (1,0x01) → no strobes for 0xAA/0xBB. locked=0 until the 0x01 capture, then out_d0=0x01. err_cnt=0.
- Locked, beats (1,0x10),(0,0x20),(1,0x30) → sync_err pulses on the third beat. out_d0=0x30. out_d1 stays 0x20. frame_cnt unchanged. err_cnt=1. locked stays 1.
- Complete frame, then (0,0x44) → sync_err pulse, locked=0, no out_valid. err_cnt increments. out_d0 unchanged.
- Frame 0x01,0x02,0x03 with in_valid=0 gaps of 3 cycles between beats → identical results to the gapless case. No strobes during gaps.
- Assert rst_n=0 asynchronously (between clock edges) after slot 1 → all outputs 0 immediately.
- Force 300 errors → err_cnt saturates at 0xFF.
- Run 65537 frames → frame_cnt=1.
